// File: rtl/wormhole_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking and credit gating.
// Drives input-buffer dequeue (grant_o) and crossbar selects (sel_o) for a 5-port mesh router.
//
// state     | meaning
// ----------|------------------------------------------------------------
// ST_IDLE   | output free; round-robin search among eligible requesters
// ST_LOCKED | output owned by `owner` until that input's tail flit passes
module wormhole_switch_allocator #(
   parameter int NUM_PORTS  = 5,
   parameter int CREDIT_W   = 3,
   parameter int MAX_CREDIT = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS-1:0]            req_i,
   input  logic [NUM_PORTS*NUM_PORTS-1:0]  dest_i,
   input  logic [NUM_PORTS-1:0]            tail_i,
   input  logic [NUM_PORTS-1:0]            credit_inc_i,
   output logic [NUM_PORTS-1:0]            grant_o,
   output logic [3*NUM_PORTS-1:0]          sel_o,
   output logic [NUM_PORTS-1:0]            out_valid_o,
   output logic [NUM_PORTS-1:0]            lock_o,
   output logic [CREDIT_W*NUM_PORTS-1:0]   credit_o,
   output logic                            err_o
);
   localparam int                   IDX_W      = 3;
   localparam logic [IDX_W-1:0]     SEL_IDLE   = '1;
   localparam logic [0:0]           ST_IDLE    = 1'b0;
   localparam logic [0:0]           ST_LOCKED  = 1'b1;
   localparam logic [CREDIT_W-1:0]  CREDIT_MAX = CREDIT_W'(MAX_CREDIT);

   logic [0:0]           state  [NUM_PORTS];
   logic [IDX_W-1:0]     owner  [NUM_PORTS];
   logic [IDX_W-1:0]     rr_ptr [NUM_PORTS];
   logic [CREDIT_W-1:0]  credit [NUM_PORTS];
   logic                 err_q;

   logic [NUM_PORTS-1:0] dest_ok;
   logic [NUM_PORTS-1:0] bad_req;
   logic [NUM_PORTS-1:0] cand [NUM_PORTS];
   logic [NUM_PORTS-1:0] win_valid;
   logic [IDX_W-1:0]     win [NUM_PORTS];
   logic [NUM_PORTS-1:0] sat;

   function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
      return (int'(v) == NUM_PORTS - 1) ? '0 : v + 1'b1;
   endfunction

   // cand[j][i]: input i has a well-formed request aimed at output j
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         dest_ok[i] = $onehot(dest_i[NUM_PORTS*i +: NUM_PORTS]);
         bad_req[i] = req_i[i] & ~dest_ok[i];
      end
      for (int j = 0; j < NUM_PORTS; j++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand[j][i] = req_i[i] & dest_ok[i] & dest_i[NUM_PORTS*i + j];
         end
      end
   end

   // One-hot dest guarantees an input appears in at most one cand row, so no double grants.
   always_comb begin
      int               p;
      logic [IDX_W-1:0] idx;
      p   = 0;
      idx = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         win_valid[j] = 1'b0;
         win[j]       = SEL_IDLE;
         if (!rst && credit[j] != '0) begin
            if (state[j] == ST_LOCKED) begin
               if (cand[j][owner[j]]) begin
                  win_valid[j] = 1'b1;
                  win[j]       = owner[j];
               end
            end else begin
               for (int k = 0; k < NUM_PORTS; k++) begin
                  p = int'(rr_ptr[j]) + k;
                  if (p >= NUM_PORTS) p = p - NUM_PORTS;
                  idx = IDX_W'(p);
                  if (!win_valid[j] && cand[j][idx]) begin
                     win_valid[j] = 1'b1;
                     win[j]       = idx;
                  end
               end
            end
         end
         sat[j] = credit_inc_i[j] & ~win_valid[j] & (credit[j] == CREDIT_MAX);
      end
   end

   always_comb begin
      grant_o     = '0;
      sel_o       = '1;
      out_valid_o = '0;
      lock_o      = '0;
      credit_o    = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
         out_valid_o[j] = win_valid[j];
         lock_o[j]      = (state[j] == ST_LOCKED);
         if (state[j] == ST_LOCKED) sel_o[3*j +: 3] = owner[j];
         else if (win_valid[j])     sel_o[3*j +: 3] = win[j];
         if (win_valid[j]) grant_o[win[j]] = 1'b1;
         credit_o[CREDIT_W*j +: CREDIT_W] = credit[j];
      end
   end

   assign err_o = err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            state[j]  <= ST_IDLE;
            owner[j]  <= '0;
            rr_ptr[j] <= '0;
            credit[j] <= CREDIT_MAX;
         end
         err_q <= 1'b0;
      end else begin
         for (int j = 0; j < NUM_PORTS; j++) begin
            // While locked the owner is also the last winner, so rr_ptr stays at owner+1.
            if (win_valid[j]) begin
               rr_ptr[j] <= wrap_inc(win[j]);
               owner[j]  <= win[j];
               state[j]  <= tail_i[win[j]] ? ST_IDLE : ST_LOCKED;
            end
            if (credit_inc_i[j] && !win_valid[j]) begin
               if (credit[j] != CREDIT_MAX) credit[j] <= credit[j] + 1'b1;
            end else if (!credit_inc_i[j] && win_valid[j]) begin
               credit[j] <= credit[j] - 1'b1;
            end
         end
         err_q <= err_q | (|bad_req) | (|sat);
      end
   end
endmodule
